riscv_hwloop_ctrl: RTL and testbench
====================================

Name: riscv_hwloop_ctrl

Overview:
Consumer side of the hardware-loop register file. The block sits in the IF stage and compares each fetched PC against the loop end addresses and counters held in the hwloop register file. On a match it issues a registered jump request to the prefetcher. It also drives the one-hot decrement request back to the register file and holds that request until the ID stage signals valid.

Parameters:
N_REGS, 2, number of hardware loop register sets; index 0 is the innermost loop and has the highest priority.
N_REG_BITS, $clog2(N_REGS), width of a loop index.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
pc_i  in  32  address of the fetched instruction.
pc_valid_i  in  1  pc_i is valid this cycle.
pc_ready_o  out  1  the block can evaluate pc_i; a transfer occurs when pc_valid_i && pc_ready_o.
hwlp_start_addr_i  in  N_REGS x 32  loop start addresses from the register file.
hwlp_end_addr_i  in  N_REGS x 32  loop end addresses (address of the last body instruction).
hwlp_counter_i  in  N_REGS x 32  loop counters from the register file.
valid_i  in  1  ID stage valid; the same signal that gates decrement in the register file.
jump_ack_i  in  1  prefetcher accepted the jump.
flush_i  in  1  branch/exception kill.
hwlp_jump_o  out  1  jump request.
hwlp_targ_addr_o  out  32  jump target.
hwlp_dec_cnt_o  out  N_REGS  one-hot decrement request to the register file.
hwlp_jump_cnt_o  out  32  count of taken loop jumps (see Optional Feature).

Behaviour:
- Reset values: hwlp_jump_o=0, hwlp_targ_addr_o=0, hwlp_dec_cnt_o=0, hwlp_jump_cnt_o=0, state=IDLE, pc_ready_o=1.
- pc_ready_o = (state==IDLE) && !flush_i. It is purely combinational.
- Effective counter: eff[k] = hwlp_counter_i[k] - dec_pend[k]. This is 32-bit unsigned; the subtract is applied only while dec_pend[k] is set.
- Match condition for loop k: pc_i == end[k] && eff[k] != 0.
- Selection: the lowest matching index wins. At most one loop is acted on per PC, so hwlp_dec_cnt_o is never multi-hot.
- Match cycle T (a transfer occurred):
  - If eff[k] > 1, it is a taken loop. At T+1: hwlp_jump_o=1, hwlp_targ_addr_o=start[k], hwlp_dec_cnt_o=onehot(k). Next state JUMP_DEC.
  - If eff[k] == 1, it is the last iteration. At T+1: hwlp_dec_cnt_o=onehot(k), hwlp_jump_o=0, fall through. Next state DEC.
- No match, or counter 0: no action; the state stays IDLE.
- FSM states and transitions:
  - IDLE: on a taken match go to JUMP_DEC; on a last-iteration match go to DEC; otherwise stay.
  - JUMP_DEC: on jump_ack_i && valid_i go to IDLE; on jump_ack_i only go to DEC; on valid_i only go to JUMP.
  - JUMP: on jump_ack_i go to IDLE.
  - DEC: on valid_i go to IDLE.
- Output holding: hwlp_jump_o and hwlp_targ_addr_o stay stable from assertion until the cycle jump_ack_i is sampled high. They clear in the following cycle.
- Decrement handshake: hwlp_dec_cnt_o stays stable until valid_i is sampled high. It clears in the following cycle, which is the same edge on which the register file decrements. The register file therefore never decrements twice for one match.
- Stale counter values: the eff[] subtraction covers pending decrements, so counters are consistent even if the register file update lags.
- flush_i: has priority over every transition. Next cycle: state=IDLE, jump/dec outputs=0, targ=0. A decrement pending in the same cycle as valid_i is still consumed by the register file in that cycle; the flush drops only the outstanding request. pc_ready_o is 0 during the flush cycle.
- rst mid-operation: next cycle all outputs return to their reset values, regardless of state.
- Address compare: exact 32-bit equality. No wrap-around handling is required; a start address above the end address is legal and jumps as programmed.

Optional Feature:
RISCV_HWLP_STATS_EN
- Defined: hwlp_jump_cnt_o is a 32-bit counter. It increments on each IDLE->JUMP_DEC transition, wraps from 0xFFFFFFFF to 0, and is cleared only by rst (flush_i does not clear it).
- Undefined: the port exists but is tied to 0, and no counter flops are inferred.

Test Plan:
- Taken loop: end[0]=0x100, start[0]=0x0F0, counter[0]=3, pc_i=0x100 valid at T -> T+1 jump_o=1, targ=0x0F0, dec_cnt_o=2'b01; valid_i and jump_ack_i both at T+1 -> all outputs 0 at T+2, pc_ready_o=1.
- Last iteration: counter[0]=1, pc_i=end[0] -> dec_cnt_o=2'b01, jump_o=0; with valid_i held low for 3 cycles, dec_cnt_o stays held and pc_ready_o=0 until valid_i=1.
- Nested priority: end[0]=end[1]=0x200, counter[0]=2, counter[1]=5, pc_i=0x200 -> dec_cnt_o=2'b01, targ=start[0]; loop 1 is untouched.
- Split handshake: after a taken match, jump_ack_i at T+1 and valid_i at T+3 -> jump_o clears at T+2, dec_cnt_o stays held through T+3 and clears at T+4.
- Flush: flush_i=1 in state JUMP_DEC with no ack -> next cycle jump_o=0, dec_cnt_o=0, state IDLE; also counter[0]=0 at end[0] -> no action.
- With RISCV_HWLP_STATS_EN defined: 4 taken jumps, 1 fall-through and 1 flush -> hwlp_jump_cnt_o=4; with the macro undefined -> hwlp_jump_cnt_o=0.

Source files
------------

// File: rtl/riscv_hwloop_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_hwloop_ctrl
//
// Hardware-loop controller in the IF stage. Each fetched PC is compared
// against the loop end addresses held in the hwloop register file. When the
// PC hits the end of an active loop, the block does two things:
//   - if more iterations remain, it issues a registered jump request to the
//     prefetcher, targeting the loop start;
//   - in every case it raises a one-hot decrement request to the register
//     file and holds it until the ID stage signals valid.
// Loop index 0 is the innermost loop and wins when several loops match.
//
// Optional build macro:
//   RISCV_HWLP_STATS_EN : when defined, hwlp_jump_cnt_o counts taken loop
//                         jumps (32-bit, wrapping, cleared only by rst).
//                         When undefined, the port is tied to zero.
//
// Ports:
//   clk                in   clock, all logic on posedge
//   rst                in   synchronous active-high reset
//   pc_i               in   fetched instruction address
//   pc_valid_i         in   pc_i valid this cycle
//   pc_ready_o         out  block can evaluate pc_i (IDLE and no flush)
//   hwlp_start_addr_i  in   per-loop start addresses
//   hwlp_end_addr_i    in   per-loop end addresses (last body instruction)
//   hwlp_counter_i     in   per-loop iteration counters
//   valid_i            in   ID stage valid (gates decrement in register file)
//   jump_ack_i         in   prefetcher accepted the jump
//   flush_i            in   branch/exception kill
//   hwlp_jump_o        out  jump request
//   hwlp_targ_addr_o   out  jump target
//   hwlp_dec_cnt_o     out  one-hot decrement request
//   hwlp_jump_cnt_o    out  taken-jump counter (optional feature)
// -----------------------------------------------------------------------------
module riscv_hwloop_ctrl #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pc_i,
  input  logic                    pc_valid_i,
  output logic                    pc_ready_o,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  input  logic                    valid_i,
  input  logic                    jump_ack_i,
  input  logic                    flush_i,
  output logic                    hwlp_jump_o,
  output logic [31:0]             hwlp_targ_addr_o,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
  output logic [31:0]             hwlp_jump_cnt_o
);

  // JUMP_DEC : jump and decrement both outstanding
  // JUMP     : decrement consumed, waiting for jump acknowledge
  // DEC      : jump consumed (or never issued), waiting for ID valid
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    JUMP_DEC = 2'd1,
    JUMP     = 2'd2,
    DEC      = 2'd3
  } state_e;

  state_e                  state_q;
  state_e                  state_d;

  logic [N_REGS-1:0][31:0] eff_cnt;
  logic                    match_found;
  logic [N_REG_BITS-1:0]   match_idx;
  logic                    pc_xfer;
  logic                    match_taken;
  logic                    match_last;

  logic                    jump_d;
  logic [31:0]             targ_d;
  logic [N_REGS-1:0]       dec_d;

  // ---------------------------------------------------------------------------
  // Effective counters: a decrement we have requested but the register file
  // may not yet reflect is subtracted here, so a stale counter never causes
  // an extra iteration.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_REGS; k++) begin
      eff_cnt[k] = hwlp_counter_i[k] - {31'd0, hwlp_dec_cnt_o[k]};
    end
  end

  // Lowest index wins: scanning downward lets lower indices overwrite.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    match_found = 1'b0;
    match_idx   = '0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (pc_i == hwlp_end_addr_i[k] && eff_cnt[k] != 32'd0) begin
        match_found = 1'b1;
        match_idx   = N_REG_BITS'(k);
      end
    end
  end

  assign pc_ready_o  = (state_q == IDLE) && !flush_i;
  assign pc_xfer     = pc_valid_i && pc_ready_o;
  assign match_taken = pc_xfer && match_found && (eff_cnt[match_idx] >  32'd1);
  assign match_last  = pc_xfer && match_found && (eff_cnt[match_idx] == 32'd1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; flush overrides every transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match_taken)     state_d = JUMP_DEC;
          else if (match_last) state_d = DEC;
        end
        JUMP_DEC: begin
          if (jump_ack_i && valid_i) state_d = IDLE;
          else if (jump_ack_i)       state_d = DEC;
          else if (valid_i)          state_d = JUMP;
        end
        JUMP: if (jump_ack_i) state_d = IDLE;
        DEC:  if (valid_i)    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered request outputs. Requests
  // hold until their own handshake is sampled, then clear independently.
  // ---------------------------------------------------------------------------
  always_comb begin
    jump_d = hwlp_jump_o;
    targ_d = hwlp_targ_addr_o;
    dec_d  = hwlp_dec_cnt_o;
    if (flush_i) begin
      // A decrement consumed this same cycle by valid_i still lands in the
      // register file; only the outstanding request is dropped here.
      jump_d = 1'b0;
      targ_d = 32'd0;
      dec_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match_taken) begin
            jump_d           = 1'b1;
            targ_d           = hwlp_start_addr_i[match_idx];
            dec_d            = '0;
            dec_d[match_idx] = 1'b1;
          end else if (match_last) begin
            dec_d            = '0;
            dec_d[match_idx] = 1'b1;
          end
        end
        JUMP_DEC: begin
          if (jump_ack_i) begin
            jump_d = 1'b0;
            targ_d = 32'd0;
          end
          if (valid_i) dec_d = '0;
        end
        JUMP: begin
          if (jump_ack_i) begin
            jump_d = 1'b0;
            targ_d = 32'd0;
          end
        end
        DEC: if (valid_i) dec_d = '0;
        default: begin
          jump_d = 1'b0;
          targ_d = 32'd0;
          dec_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwlp_jump_o      <= 1'b0;
      hwlp_targ_addr_o <= 32'd0;
      hwlp_dec_cnt_o   <= '0;
    end else begin
      hwlp_jump_o      <= jump_d;
      hwlp_targ_addr_o <= targ_d;
      hwlp_dec_cnt_o   <= dec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Taken-jump statistics
  // ---------------------------------------------------------------------------
`ifdef RISCV_HWLP_STATS_EN
  logic [31:0] jump_cnt_q;

  // A flush in the match cycle forces state_d to IDLE, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst)                                         jump_cnt_q <= 32'd0;
    else if (state_q == IDLE && state_d == JUMP_DEC) jump_cnt_q <= jump_cnt_q + 32'd1;
  end

  assign hwlp_jump_cnt_o = jump_cnt_q;
`else
  assign hwlp_jump_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_hwloop_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for riscv_hwloop_ctrl. Inputs change 1 ns after the
// rising edge and outputs are checked there, away from the active edge.
// -----------------------------------------------------------------------------
module tb_riscv_hwloop_ctrl;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         pc;
  logic                pc_valid;
  logic                pc_ready;
  logic [1:0][31:0]    start_addr;
  logic [1:0][31:0]    end_addr;
  logic [1:0][31:0]    counter;
  logic                valid;
  logic                jump_ack;
  logic                flush;
  logic                hwlp_jump;
  logic [31:0]         hwlp_targ;
  logic [1:0]          hwlp_dec;
  logic [31:0]         hwlp_jump_cnt;

  int n_checks = 0;
  int n_errors = 0;

  riscv_hwloop_ctrl #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc),
    .pc_valid_i        (pc_valid),
    .pc_ready_o        (pc_ready),
    .hwlp_start_addr_i (start_addr),
    .hwlp_end_addr_i   (end_addr),
    .hwlp_counter_i    (counter),
    .valid_i           (valid),
    .jump_ack_i        (jump_ack),
    .flush_i           (flush),
    .hwlp_jump_o       (hwlp_jump),
    .hwlp_targ_addr_o  (hwlp_targ),
    .hwlp_dec_cnt_o    (hwlp_dec),
    .hwlp_jump_cnt_o   (hwlp_jump_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the four request-side outputs at once.
  task automatic check_out(input string tag, input logic j, input logic [31:0] t,
                           input logic [1:0] d, input logic r);
    check({tag, ".jump"},  {31'd0, hwlp_jump}, {31'd0, j});
    check({tag, ".targ"},  hwlp_targ,          t);
    check({tag, ".dec"},   {30'd0, hwlp_dec},  {30'd0, d});
    check({tag, ".ready"}, {31'd0, pc_ready},  {31'd0, r});
  endtask

  initial begin
    rst        = 1'b1;
    pc         = 32'd0;
    pc_valid   = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    counter    = '0;
    valid      = 1'b0;
    jump_ack   = 1'b0;
    flush      = 1'b0;
    tick();
    tick();
    check_out("reset", 1'b0, 32'd0, 2'b00, 1'b1);
    check("reset.cnt", hwlp_jump_cnt, 32'd0);
    rst = 1'b0;

    // Taken loop, jump and decrement handshakes together.
    end_addr[0]   = 32'h100; start_addr[0] = 32'h0F0; counter[0] = 32'd3;
    end_addr[1]   = 32'h500; start_addr[1] = 32'h400; counter[1] = 32'd0;
    pc = 32'h100; pc_valid = 1'b1;
    tick();
    check_out("taken.t1", 1'b1, 32'h0F0, 2'b01, 1'b0);
    pc_valid = 1'b0; valid = 1'b1; jump_ack = 1'b1;
    tick();
    counter[0] = 32'd2;
    valid = 1'b0; jump_ack = 1'b0;
    check_out("taken.t2", 1'b0, 32'd0, 2'b00, 1'b1);

    // Last iteration: fall through, decrement held until valid.
    counter[0] = 32'd1;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("last.t1", 1'b0, 32'd0, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("last.hold%0d", i), 1'b0, 32'd0, 2'b01, 1'b0);
    end
    valid = 1'b1;
    tick();
    valid = 1'b0;
    counter[0] = 32'd0;
    check_out("last.done", 1'b0, 32'd0, 2'b00, 1'b1);

    // Counter zero at the end address: no action.
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("zero", 1'b0, 32'd0, 2'b00, 1'b1);

    // PC off the end address: no action.
    counter[0] = 32'd4; pc = 32'h104; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("nomatch", 1'b0, 32'd0, 2'b00, 1'b1);

    // Nested loops sharing an end address: index 0 wins.
    end_addr[0] = 32'h200; start_addr[0] = 32'h1C0; counter[0] = 32'd2;
    end_addr[1] = 32'h200; start_addr[1] = 32'h180; counter[1] = 32'd5;
    pc = 32'h200; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("nest.t1", 1'b1, 32'h1C0, 2'b01, 1'b0);
    valid = 1'b1; jump_ack = 1'b1;
    tick();
    valid = 1'b0; jump_ack = 1'b0;
    counter[0] = 32'd1;
    check_out("nest.t2", 1'b0, 32'd0, 2'b00, 1'b1);

    // Split handshake: ack at T+1, valid at T+3.
    counter[0] = 32'd3; counter[1] = 32'd0;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("split.t1", 1'b1, 32'h1C0, 2'b01, 1'b0);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    check_out("split.t2", 1'b0, 32'd0, 2'b01, 1'b0);
    tick();
    check_out("split.t3", 1'b0, 32'd0, 2'b01, 1'b0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    counter[0] = 32'd2;
    check_out("split.t4", 1'b0, 32'd0, 2'b00, 1'b1);

    // Flush in JUMP_DEC with no acknowledge.
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("flush.t1", 1'b1, 32'h1C0, 2'b01, 1'b0);
    flush = 1'b1;
    tick();
    check_out("flush.t2", 1'b0, 32'd0, 2'b00, 1'b0);
    // Flush in IDLE blocks a matching PC from being accepted.
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("flush.block", 1'b0, 32'd0, 2'b00, 1'b0);
    flush = 1'b0;
    #1;
    check("flush.ready", {31'd0, pc_ready}, 32'd1);

`ifdef RISCV_HWLP_STATS_EN
    check("stats.cnt", hwlp_jump_cnt, 32'd4);
`else
    check("stats.cnt", hwlp_jump_cnt, 32'd0);
`endif

    // Reset in the middle of a loop jump.
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check_out("rst.t1", 1'b1, 32'h1C0, 2'b01, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rst.t2", 1'b0, 32'd0, 2'b00, 1'b1);
    check("rst.cnt", hwlp_jump_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
